// File: rtl/md5_block_engine.sv
// MD5 compression engine: 64 steps on one 512-bit block, UNROLL steps per clock, with chaining.
// Define MD5_FEEDFORWARD_EN to add the saved IV into the result (true MD5 chaining value).
module md5_block_engine #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic         chain,
  input  logic [511:0] msg,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  output logic         valid,
  input  logic         out_ready,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("md5_block_engine: UNROLL must be 1, 2 or 4");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amount depends only on the round and step mod 4
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  logic [1:0]   state;
  logic [5:0]   cnt;
  logic [511:0] blk;
  logic [31:0]  ra, rb, rc, rd;
  logic [31:0]  ia, ib, ic, id;
  logic [31:0]  na, nb, nc, nd;
  logic [31:0]  f, t;
  logic [5:0]   idx;
  logic [3:0]   g, lo;
`ifdef MD5_FEEDFORWARD_EN
  logic [31:0]  s0, s1, s2, s3;
`endif

  assign ia = chain ? a_out : a_in;
  assign ib = chain ? b_out : b_in;
  assign ic = chain ? c_out : c_in;
  assign id = chain ? d_out : d_in;

  assign ready = (state == IDLE);
  assign valid = (state == DONE);
  assign busy  = (state == RUN) || (state == FINAL);

  always_comb begin
    na  = ra;
    nb  = rb;
    nc  = rc;
    nd  = rd;
    f   = '0;
    t   = '0;
    idx = '0;
    g   = '0;
    lo  = '0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      idx = cnt + 6'(u);
      lo  = idx[3:0];
      case (idx[5:4])
        2'd0:    begin f = (nb & nc) | (~nb & nd); g = lo;                end
        2'd1:    begin f = (nd & nb) | (~nd & nc); g = lo * 4'd5 + 4'd1;  end
        2'd2:    begin f = nb ^ nc ^ nd;           g = lo * 4'd3 + 4'd5;  end
        default: begin f = nc ^ (nb | ~nd);        g = lo * 4'd7;         end
      endcase
      t  = na + f + K_TAB[idx] + blk[{g, 5'd0} +: 32];
      t  = nb + rotl(t, S_TAB[{idx[5:4], idx[1:0]}]);
      na = nd;
      nd = nc;
      nc = nb;
      nb = t;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_out <= '0;
      b_out <= '0;
      c_out <= '0;
      d_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            blk   <= msg;
            ra    <= ia;
            rb    <= ib;
            rc    <= ic;
            rd    <= id;
`ifdef MD5_FEEDFORWARD_EN
            s0    <= ia;
            s1    <= ib;
            s2    <= ic;
            s3    <= id;
`endif
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          ra  <= na;
          rb  <= nb;
          rc  <= nc;
          rd  <= nd;
          cnt <= cnt + 6'(UNROLL);
          if (cnt == 6'(64 - UNROLL)) state <= FINAL;
        end
        FINAL: begin
`ifdef MD5_FEEDFORWARD_EN
          a_out <= s0 + ra;
          b_out <= s1 + rb;
          c_out <= s2 + rc;
          d_out <= s3 + rd;
`else
          a_out <= ra;
          b_out <= rb;
          c_out <= rc;
          d_out <= rd;
`endif
          state <= DONE;
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_block_engine.sv
// Directed bench for md5_block_engine at UNROLL 1/2/4; expectations follow MD5_FEEDFORWARD_EN.
module tb_md5_block_engine;

  localparam logic [127:0] IV        = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [511:0] EMPTY_MSG = 512'h80;
  localparam logic [511:0] OTHER_MSG = {16{32'hdeadbeef}};
`ifdef MD5_FEEDFORWARD_EN
  localparam logic [127:0] EXP_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
`else
  localparam logic [127:0] EXP_EMPTY = 128'h7246fad3_14e45506_ff4ea3eb_6e10a476;
`endif

  logic         clk = 1'b0;
  logic         reset, chain, out_ready;
  logic [2:0]   start, ready, valid, busy;
  logic [511:0] msg;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [31:0]  a_o [3];
  logic [31:0]  b_o [3];
  logic [31:0]  c_o [3];
  logic [31:0]  d_o [3];
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  md5_block_engine #(.UNROLL(1)) u_e1 (
    .clk(clk), .reset(reset), .start(start[0]), .ready(ready[0]), .chain(chain), .msg(msg),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .valid(valid[0]), .out_ready(out_ready),
    .a_out(a_o[0]), .b_out(b_o[0]), .c_out(c_o[0]), .d_out(d_o[0]), .busy(busy[0])
  );
  md5_block_engine #(.UNROLL(2)) u_e2 (
    .clk(clk), .reset(reset), .start(start[1]), .ready(ready[1]), .chain(chain), .msg(msg),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .valid(valid[1]), .out_ready(out_ready),
    .a_out(a_o[1]), .b_out(b_o[1]), .c_out(c_o[1]), .d_out(d_o[1]), .busy(busy[1])
  );
  md5_block_engine #(.UNROLL(4)) u_e4 (
    .clk(clk), .reset(reset), .start(start[2]), .ready(ready[2]), .chain(chain), .msg(msg),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .valid(valid[2]), .out_ready(out_ready),
    .a_out(a_o[2]), .b_out(b_o[2]), .c_out(c_o[2]), .d_out(d_o[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] res(input int i);
    return {a_o[i], b_o[i], c_o[i], d_o[i]};
  endfunction

  // Reference compression; K derived from sin() rather than a typed table
  function automatic logic [127:0] md5_model(input logic [511:0] m, input logic [127:0] iv);
    logic [31:0] a, b, c, d, f, t, kk;
    int unsigned g, s;
    real x;
    int unsigned sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    {a, b, c, d} = iv;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                         end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16;          end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16;          end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;              end
      x  = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      kk = 32'(longint'($floor(x * 4294967296.0)));
      s  = sh[(i / 16) * 4 + i % 4];
      t  = a + f + kk + m[g * 32 +: 32];
      t  = (t << s) | (t >> (32 - s));
      a  = d;
      d  = c;
      c  = b;
      b  = b + t;
    end
`ifdef MD5_FEEDFORWARD_EN
    return {iv[127:96] + a, iv[95:64] + b, iv[63:32] + c, iv[31:0] + d};
`else
    return {a, b, c, d};
`endif
  endfunction

  // Accept edge happens inside; inputs are scrambled afterwards
  task automatic launch(input int i, input logic [511:0] m, input logic [127:0] iv, input logic ch);
    msg   = m;
    {a_in, b_in, c_in, d_in} = iv;
    chain = ch;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    chk("accept_busy", busy[i], 1);
    chk("accept_ready", ready[i], 0);
    msg   = {16{$urandom()}};
    a_in  = $urandom();
    b_in  = $urandom();
    c_in  = $urandom();
    d_in  = $urandom();
    chain = ~ch;
  endtask

  task automatic wait_valid(input int i, output int n);
    n = 0;
    while (!valid[i] && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, vcount;
    logic [127:0] r, exp1, exp2;
    logic [511:0] blk1, blk2;
    int unrl [3] = '{1, 2, 4};

    reset = 1'b1; start = '0; chain = 1'b0; out_ready = 1'b1;
    msg = '0; a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    @(posedge clk); #1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", ready[i], 1);
      chk("rst_valid", valid[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_out", res(i), '0);
    end

    // Empty-string block on every unroll width
    for (int i = 0; i < 3; i++) begin
      launch(i, EMPTY_MSG, IV, 1'b0);
      wait_valid(i, n);
      chk("empty_latency", n, 64 / unrl[i] + 1);
      chk("empty_digest", res(i), EXP_EMPTY);
      tick();
      chk("release_ready", ready[i], 1);
      chk("release_valid", valid[i], 0);
    end

    // Back-pressure: result held, start ignored while DONE
    out_ready = 1'b0;
    launch(0, OTHER_MSG, IV, 1'b0);
    wait_valid(0, n);
    chk("bp_latency", n, 65);
    r = res(0);
    chk("bp_digest", r, md5_model(OTHER_MSG, IV));
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        msg = EMPTY_MSG;
        start[0] = 1'b1;
      end
      tick();
      start[0] = 1'b0;
      chk("bp_valid", valid[0], 1);
      chk("bp_ready", ready[0], 0);
      chk("bp_out", res(0), r);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", ready[0], 1);
    chk("bp_release_valid", valid[0], 0);
    launch(0, EMPTY_MSG, IV, 1'b0);
    wait_valid(0, n);
    chk("bp_next_latency", n, 65);
    chk("bp_next_digest", res(0), EXP_EMPTY);
    tick();

    // Start during RUN is ignored
    launch(0, EMPTY_MSG, IV, 1'b0);
    repeat (10) tick();
    msg = OTHER_MSG;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("run_start_busy", busy[0], 1);
    wait_valid(0, n);
    chk("run_start_latency", n + 11, 65);
    chk("run_start_digest", res(0), EXP_EMPTY);
    tick();

    // Reset mid-run aborts; chain=1 then starts from zero
    launch(0, EMPTY_MSG, IV, 1'b0);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", ready[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_out", res(0), '0);
    vcount = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (valid[0]) vcount++;
    end
    chk("abort_no_valid", vcount, 0);
    launch(0, EMPTY_MSG, IV, 1'b1);
    wait_valid(0, n);
    chk("zero_chain_digest", res(0), md5_model(EMPTY_MSG, '0));
    tick();
    launch(0, EMPTY_MSG, IV, 1'b0);
    wait_valid(0, n);
    chk("after_abort_digest", res(0), EXP_EMPTY);
    tick();

    // Two-block message: 56 x 'a'
    blk1 = '0;
    blk2 = '0;
    for (int w = 0; w < 14; w++) blk1[w * 32 +: 32] = 32'h61616161;
    blk1[14 * 32 +: 32] = 32'h00000080;
    blk2[14 * 32 +: 32] = 32'h000001c0;
    exp1 = md5_model(blk1, IV);
    exp2 = md5_model(blk2, exp1);
    launch(0, blk1, IV, 1'b0);
    wait_valid(0, n);
    chk("blk1_digest", res(0), exp1);
    tick();
    launch(0, blk2, {4{$urandom()}}, 1'b1);
    wait_valid(0, n);
    chk("blk2_chain_latency", n, 65);
    chk("blk2_chain_digest", res(0), exp2);
    tick();
    launch(0, blk2, IV, 1'b0);
    wait_valid(0, n);
    r = res(0);
    chk("blk2_iv_digest", r, md5_model(blk2, IV));
    chk("blk2_iv_differs", r != exp2, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
